iobs_port: RTL and testbench

IOBS_PORT -- requirements
Module: iobs_port

---
 rtl/iobs_port.sv | 129 ++++++++++++
 tb/tb_iobs_port.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/iobs_port.sv
// CPU-side I/O bus slave port: turns CPU I/O cycles into single PDS master requests.
// Optional macro IOBS_POSTED_WRITE_EN terminates writes early and finishes them in the background.
module iobs_port (
   input  logic       CLK,
   input  logic       RES,
   input  logic       BACT,
   input  logic       IOCS,
   input  logic       CPU_RnW,
   input  logic       CPU_LDS,
   input  logic       CPU_UDS,
   input  logic       IOACT,
   input  logic       IODONE,
   output logic       IOReady,
   output logic       ALE1,
   output logic       IOREQ,
   output logic       IORW,
   output logic       IOLDS,
   output logic       IOUDS,
   output logic       PWPending,
   output logic [1:0] dbg_state_o
);

   // Handshake: IOREQ is held until the master shows IOACT (synchronized); completion is
   // IODONE while in ACT, and the port waits for IOACT to drop before the next request.
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACT, ST_WAIT} state_t;

   state_t state_q, state_d;
   logic   ioact_meta_q, ioacts_q, iodone_meta_q, iodones_q;
   logic   taken_q, taken_d;
   logic   ready_q, ready_d;
   logic   iorw_q, iorw_d, iolds_q, iolds_d, iouds_q, iouds_d;
   logic   accept, posted_acc, finish, ready_now, live;

   always_comb begin
      accept = (state_q == ST_IDLE) && BACT && IOCS && !taken_q && !ioacts_q;
      finish = (state_q == ST_WAIT) && !ioacts_q;
`ifdef IOBS_POSTED_WRITE_EN
      posted_acc = accept && !CPU_RnW;
      // Posted writes already got their IOReady at acceptance.
      ready_now  = (state_q == ST_ACT) && iodones_q && taken_q && BACT && iorw_q;
`else
      posted_acc = 1'b0;
      ready_now  = (state_q == ST_ACT) && iodones_q && taken_q && BACT;
`endif
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)     state_d = ST_REQ;
         ST_REQ:  if (ioacts_q)   state_d = ST_ACT;
         ST_ACT:  if (iodones_q)  state_d = ST_WAIT;
         ST_WAIT: if (!ioacts_q)  state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase

      taken_d = BACT ? (taken_q | accept) : 1'b0;
      ready_d = BACT ? (ready_q | posted_acc | ready_now) : 1'b0;

      iorw_d  = iorw_q;
      iolds_d = iolds_q;
      iouds_d = iouds_q;
      if (accept) begin
         iorw_d  = CPU_RnW;
         iolds_d = CPU_LDS;
         iouds_d = CPU_UDS;
      end else if (finish) begin
         iorw_d  = 1'b0;
         iolds_d = 1'b0;
         iouds_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RES) begin
         state_q       <= ST_IDLE;
         ioact_meta_q  <= 1'b0;
         ioacts_q      <= 1'b0;
         iodone_meta_q <= 1'b0;
         iodones_q     <= 1'b0;
         taken_q       <= 1'b0;
         ready_q       <= 1'b0;
         iorw_q        <= 1'b0;
         iolds_q       <= 1'b0;
         iouds_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         ioact_meta_q  <= IOACT;
         ioacts_q      <= ioact_meta_q;
         iodone_meta_q <= IODONE;
         iodones_q     <= iodone_meta_q;
         taken_q       <= taken_d;
         ready_q       <= ready_d;
         iorw_q        <= iorw_d;
         iolds_q       <= iolds_d;
         iouds_q       <= iouds_d;
      end
   end

`ifdef IOBS_POSTED_WRITE_EN
   logic pw_q, pw_d;

   always_comb begin
      pw_d = pw_q;
      if (accept)      pw_d = posted_acc;
      else if (finish) pw_d = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RES) pw_q <= 1'b0;
      else     pw_q <= pw_d;
   end

   assign PWPending = !RES && pw_q;
`else
   assign PWPending = 1'b0;
`endif

   // Every output is forced low for the whole reset cycle, not just after it.
   assign live        = !RES;
   assign ALE1        = live && accept;
   assign IOREQ       = live && (state_q == ST_REQ);
   assign IORW        = live && iorw_q;
   assign IOLDS       = live && iolds_q;
   assign IOUDS       = live && iouds_q;
   assign IOReady     = live && BACT && (ready_q || ready_now);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iobs_port.sv
// Bench for iobs_port: a schedule of CPU/master transactions with expected output windows
// derived from cycle arithmetic, followed by a directed reset-mid-transfer sequence.
module tb_iobs_port;

  localparam int N = 40;

  logic       CLK = 1'b0;
  logic       RES, BACT, IOCS, CPU_RnW, CPU_LDS, CPU_UDS, IOACT, IODONE;
  logic       IOReady, ALE1, IOREQ, IORW, IOLDS, IOUDS, PWPending;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int s[N], c0[N], aa[N], dd[N], ee[N], hh[N], rr[N], be[N];
  bit io[N], rnw[N], lds[N], uds[N], posted[N];

  iobs_port dut (
    .CLK(CLK), .RES(RES), .BACT(BACT), .IOCS(IOCS), .CPU_RnW(CPU_RnW),
    .CPU_LDS(CPU_LDS), .CPU_UDS(CPU_UDS), .IOReady(IOReady), .ALE1(ALE1),
    .IOREQ(IOREQ), .IORW(IORW), .IOLDS(IOLDS), .IOUDS(IOUDS),
    .IOACT(IOACT), .IODONE(IODONE), .PWPending(PWPending), .dbg_state_o(dbg_state)
  );

  always #5 CLK = ~CLK;

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  task automatic check(input string tag, input int cyc, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all(input int cyc, input logic e_rdy, input logic e_ale, input logic e_req,
                           input logic e_rw, input logic e_l, input logic e_u, input logic e_pw);
    check("IOReady", cyc, IOReady, e_rdy);
    check("ALE1", cyc, ALE1, e_ale);
    check("IOREQ", cyc, IOREQ, e_req);
    check("IORW", cyc, IORW, e_rw);
    check("IOLDS", cyc, IOLDS, e_l);
    check("IOUDS", cyc, IOUDS, e_u);
    check("PWPending", cyc, PWPending, e_pw);
  endtask

  task automatic drive(input logic b, input logic cs, input logic rw, input logic l,
                       input logic u, input logic act, input logic done);
    BACT = b; IOCS = cs; CPU_RnW = rw; CPU_LDS = l; CPU_UDS = u; IOACT = act; IODONE = done;
  endtask

  initial begin
    int t_now, free_at, gap, t_end;
    logic b, cs, rw, l, u, act, done;
    logic e_rdy, e_ale, e_req, e_rw, e_l, e_u, e_pw;

    // ---- build the transaction schedule ----
    t_now   = 2;
    free_at = 0;
    for (int n = 0; n < N; n++) begin
      io[n] = 1'b1; gap = 2;
      case (n)
        0: begin aa[n]=3; dd[n]=10; ee[n]=14; hh[n]=3;  rnw[n]=1; lds[n]=1; uds[n]=1; end
        1: begin aa[n]=2; dd[n]=4;  ee[n]=6;  hh[n]=40; rnw[n]=1; lds[n]=1; uds[n]=0; end
        2: begin aa[n]=4; dd[n]=4;  ee[n]=6;  hh[n]=2;  rnw[n]=1; lds[n]=0; uds[n]=1; end
        3: begin aa[n]=1; dd[n]=3;  ee[n]=8;  hh[n]=0;  rnw[n]=1; lds[n]=1; uds[n]=1; gap=0; end
        4: begin aa[n]=2; dd[n]=5;  ee[n]=7;  hh[n]=2;  rnw[n]=1; lds[n]=1; uds[n]=1; end
        5: begin aa[n]=3; dd[n]=10; ee[n]=14; hh[n]=2;  rnw[n]=0; lds[n]=1; uds[n]=0; gap=0; end
        6: begin aa[n]=3; dd[n]=10; ee[n]=14; hh[n]=2;  rnw[n]=1; lds[n]=1; uds[n]=1; end
        default: begin
          io[n]  = ($urandom_range(0, 4) != 0);
          aa[n]  = $urandom_range(1, 5);
          dd[n]  = aa[n] + $urandom_range(0, 5);
          ee[n]  = imax(dd[n], aa[n] + 1) + 1 + $urandom_range(0, 3);
          hh[n]  = $urandom_range(0, 4);
          rnw[n] = 1'($urandom_range(0, 1));
          lds[n] = 1'($urandom_range(0, 1));
          uds[n] = 1'($urandom_range(0, 1));
          gap    = $urandom_range(0, 3);
        end
      endcase
`ifdef IOBS_POSTED_WRITE_EN
      posted[n] = io[n] && !rnw[n];
`else
      posted[n] = 1'b0;
`endif
      s[n] = t_now;
      if (!io[n]) begin
        c0[n] = -1000;
        be[n] = s[n] + 1 + hh[n];
      end else begin
        // A cycle arriving while the port is busy waits for the previous transfer to clear.
        c0[n]   = imax(s[n], free_at);
        rr[n]   = posted[n] ? 1 : imax(dd[n] + 2, aa[n] + 3);
        be[n]   = c0[n] + rr[n] + hh[n];
        free_at = c0[n] + ee[n] + 3;
      end
      t_now = be[n] + 1 + gap;
    end
    t_end = imax(t_now, free_at) + 4;

    // ---- reset, with an IO cycle presented to prove outputs are held low ----
    RES = 1'b1;
    drive(1, 1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (i == 2) drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      check_all(-3 + i, 0, 0, 0, 0, 0, 0, 0);
    end
    check("state_idle", -1, dbg_state == 2'd0, 1'b1);
    @(negedge CLK);
    RES = 1'b0;

    // ---- scheduled traffic ----
    for (int t = 0; t < t_end; t++) begin
      @(negedge CLK);
      b = 0; cs = 0; rw = 0; l = 0; u = 0; act = 0; done = 0;
      e_rdy = 0; e_ale = 0; e_req = 0; e_rw = 0; e_l = 0; e_u = 0; e_pw = 0;
      for (int n = 0; n < N; n++) begin
        if (t >= s[n] && t < be[n]) begin
          b = 1; cs = io[n]; rw = rnw[n]; l = lds[n]; u = uds[n];
        end
        if (io[n]) begin
          int k;
          k = t - c0[n];
          if (k >= aa[n] && k < ee[n]) act = 1;
          if (k >= dd[n] && k < ee[n]) done = 1;
          if (k == 0) e_ale = 1;
          if (k >= 1 && k <= aa[n] + 2) e_req = 1;
          if (k >= 1 && k <= ee[n] + 2) begin
            e_rw = rnw[n]; e_l = lds[n]; e_u = uds[n]; e_pw = posted[n];
          end
          if (t >= c0[n] + rr[n] && t < be[n]) e_rdy = 1;
        end
      end
      drive(b, cs, rw, l, u, act, done);
      #1;
      check_all(t, e_rdy, e_ale, e_req, e_rw, e_l, e_u, e_pw);
    end

    // ---- reset while ACT with the master still busy ----
    for (int c = 0; c < 17; c++) begin
      @(negedge CLK);
      RES = (c == 5);
      case (c)
        0, 1, 2, 3, 4: drive(1, 1, 1, 1, 1, c >= 1, 0);
        5, 6, 7, 8:    drive(0, 0, 0, 0, 0, 1, 0);
        9, 10, 11, 12: drive(1, 1, 1, 1, 1, 1, 0);
        default:       drive(1, 1, 1, 1, 1, 0, 0);
      endcase
      #1;
      case (c)
        0:             check("rst_seq_ale", 1000 + c, ALE1, 1'b1);
        3:             check("rst_seq_req", 1000 + c, IOREQ, 1'b1);
        4:             check("rst_seq_act", 1000 + c, IOREQ, 1'b0);
        5, 6:          check_all(1000 + c, 0, 0, 0, 0, 0, 0, 0);
        9, 10, 11, 12, 13, 14: begin
          check("stall_req", 1000 + c, IOREQ, 1'b0);
          check("stall_ale", 1000 + c, ALE1, 1'b0);
        end
        15: begin
          check("resume_ale", 1000 + c, ALE1, 1'b1);
          check("resume_req", 1000 + c, IOREQ, 1'b0);
        end
        16:            check("resume_req", 1000 + c, IOREQ, 1'b1);
        default: ;
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
